watch_ctrl: RTL

WATCH_CTRL -- requirements
Module: watch_ctrl

---
 rtl/watch_pkg.sv | 27 ++
 rtl/watch_ctrl_if.sv | 45 ++++
 rtl/lap_ptr.sv | 37 +++
 rtl/watch_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// ---------------------------------------------------------------------------
// watch_pkg
// Shared definitions for the stopwatch lap controller.
//   state_t       : controller state encoding (also exported on state_o)
//   SIZE_DEF      : default BCD digit width
//   MAX_ADDR_DEF  : default number of lap slots
//   ptr_width()   : bits needed for a slot counter that can reach 'slots'
// ---------------------------------------------------------------------------
package watch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSE  = 2'd2,
        REPLAY = 2'd3
    } state_t;

    localparam int SIZE_DEF     = 4;
    localparam int MAX_ADDR_DEF = 8;

    // The write pointer has to hold the value 'slots' itself (memory full),
    // so the counter needs one state more than the number of slots.
    function automatic int ptr_width(input int slots);
        return (slots < 1) ? 1 : $clog2(slots + 1);
    endfunction

endpackage

// File: rtl/watch_ctrl_if.sv
// ---------------------------------------------------------------------------
// watch_ctrl_if
// Bundles the controller's button/tick/time-digit inputs with its time
// handler and lap memory outputs.
//   master : the controller side (watch_ctrl)
//   slave  : the surrounding system (buttons, time handler, lap memory)
// ---------------------------------------------------------------------------
interface watch_ctrl_if
    import watch_pkg::*;
#(
    parameter int SIZE = SIZE_DEF
);

    logic              pulse;
    logic              start_stop;
    logic              lap;
    logic              replay;
    logic [SIZE-1:0]   seconds_units;
    logic [SIZE-1:0]   seconds_tens;
    logic [SIZE-1:0]   minutes_units;
    logic [SIZE-1:0]   minutes_tens;

    logic              pulse_fsm;
    logic              restart;
    logic              save;
    logic              we;
    logic              re;
    logic [7:0]        addr;
    logic [4*SIZE-1:0] wdata;
    logic              full;
    logic [1:0]        state_o;

    modport master (
        input  pulse, start_stop, lap, replay,
        input  seconds_units, seconds_tens, minutes_units, minutes_tens,
        output pulse_fsm, restart, save, we, re, addr, wdata, full, state_o
    );

    modport slave (
        output pulse, start_stop, lap, replay,
        output seconds_units, seconds_tens, minutes_units, minutes_tens,
        input  pulse_fsm, restart, save, we, re, addr, wdata, full, state_o
    );

endinterface

// File: rtl/lap_ptr.sv
// ---------------------------------------------------------------------------
// lap_ptr
// Slot counter counting 0..LIMIT, wrapping back to 0 when incremented at
// LIMIT. Clear has priority over increment.
//   clk, rst : clock, asynchronous active-low reset
//   clr      : synchronous clear to 0
//   inc      : advance by one slot
//   count    : current slot value
//   term     : count has reached LIMIT
// ---------------------------------------------------------------------------
module lap_ptr
    import watch_pkg::*;
#(
    parameter int WIDTH = ptr_width(MAX_ADDR_DEF),
    parameter int LIMIT = MAX_ADDR_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             term
);

    assign term = (count == WIDTH'(LIMIT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= term ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/watch_ctrl.sv
// ---------------------------------------------------------------------------
// watch_ctrl
// Stopwatch controller: gates the 1 s tick to the time handler, stores lap
// times into a small lap memory and replays them one per tick.
//   clk  : system clock, all state changes on the rising edge
//   rst  : asynchronous active-low reset
//   bus  : watch_ctrl_if.master
//          in : pulse, start_stop, lap, replay, four BCD time digits
//          out: pulse_fsm, restart, save/we/addr/wdata (lap write),
//               re/addr (lap read), full, state_o
// ---------------------------------------------------------------------------
module watch_ctrl
    import watch_pkg::*;
#(
    parameter int SIZE     = SIZE_DEF,
    parameter int MAX_ADDR = MAX_ADDR_DEF
) (
    input  logic         clk,
    input  logic         rst,
    watch_ctrl_if.master bus
);

    localparam int PTR_W = ptr_width(MAX_ADDR);

    state_t            state;
    state_t            next_state;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              wr_term;
    logic              rd_term;

    logic              ss_btn;
    logic              lap_btn;
    logic              replay_btn;
    logic              last_read;

    logic              restart_c;
    logic              lap_take;
    logic              wr_clr;
    logic              rd_clr;
    logic              re_c;

    logic              we_q;
    logic [PTR_W-1:0]  wr_addr_q;
    logic [4*SIZE-1:0] wdata_q;

    // Button priority start_stop > lap > replay: a lower button pressed in
    // the same cycle as a higher one is simply dropped.
    assign ss_btn     = bus.start_stop;
    assign lap_btn    = bus.lap & ~bus.start_stop;
    assign replay_btn = bus.replay & ~bus.start_stop & ~bus.lap;

    // The read in progress is the last one when it targets the newest
    // written slot; rd_term guards the case where every slot was written.
    assign last_read = (rd_ptr + PTR_W'(1) == wr_ptr) || rd_term;

    lap_ptr #(
        .WIDTH (PTR_W),
        .LIMIT (MAX_ADDR)
    ) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr   (wr_clr),
        .inc   (lap_take),
        .count (wr_ptr),
        .term  (wr_term)
    );

    lap_ptr #(
        .WIDTH (PTR_W),
        .LIMIT (MAX_ADDR - 1)
    ) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr   (rd_clr),
        .inc   (re_c),
        .count (rd_ptr),
        .term  (rd_term)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (ss_btn) next_state = RUN;
            end
            RUN: begin
                if (ss_btn) next_state = PAUSE;
            end
            PAUSE: begin
                if (ss_btn)                               next_state = RUN;
                else if (lap_btn)                         next_state = IDLE;
                else if (replay_btn && wr_ptr != '0)      next_state = REPLAY;
            end
            REPLAY: begin
                if (ss_btn)                               next_state = PAUSE;
                else if (bus.pulse && last_read)          next_state = PAUSE;
            end
        endcase
    end

    // Mealy strobes. The write pointer advances at the lap edge itself, so
    // the slot index and digits are captured for the following write cycle.
    always_comb begin
        restart_c = 1'b0;
        lap_take  = 1'b0;
        wr_clr    = 1'b0;
        rd_clr    = 1'b0;
        re_c      = 1'b0;
        case (state)
            IDLE: begin
                if (ss_btn) begin
                    restart_c = 1'b1;
                    wr_clr    = 1'b1;
                end
            end
            RUN: begin
                lap_take = lap_btn & ~wr_term;
            end
            PAUSE: begin
                restart_c = lap_btn;
                rd_clr    = replay_btn & (wr_ptr != '0);
            end
            REPLAY: begin
                re_c = bus.pulse & ~ss_btn;
            end
        endcase
    end

    // One-cycle write stage; it runs independently of the state so a write
    // still lands when start_stop pauses the watch in the following cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q      <= 1'b0;
            wr_addr_q <= '0;
            wdata_q   <= '0;
        end else begin
            we_q <= lap_take;
            if (lap_take) begin
                wr_addr_q <= wr_ptr;
                wdata_q   <= {bus.minutes_tens, bus.minutes_units,
                              bus.seconds_tens, bus.seconds_units};
            end
        end
    end

    // restart is gated by rst because in reset the state already reads IDLE
    // and a held start_stop would otherwise leak through.
    assign bus.pulse_fsm = bus.pulse & (state == RUN);
    assign bus.restart   = restart_c & rst;
    assign bus.we        = we_q;
    assign bus.save      = we_q;
    assign bus.re        = re_c;
    assign bus.wdata     = wdata_q;
    assign bus.full      = wr_term;
    assign bus.state_o   = state;
    assign bus.addr      = we_q ? 8'(wr_addr_q) :
                           re_c ? 8'(rd_ptr)    : 8'(wr_ptr);

endmodule
